// File: rtl/fp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_ctrl_pkg
//  Description : Shared defaults and limits for the FP pipeline stage-enable
//                sequencer and its delay sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_ctrl_pkg;

    localparam int DEF_CNT_W      = 4;
    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_STAGE_DLY  = 10;

    localparam int MAX_STAGES     = 8;
    localparam int MAX_STAGE_DLY  = 64;

endpackage
`default_nettype wire

// File: rtl/fp_pulse_delay.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pulse_delay
//  Description : Fixed DLY-cycle registered delay line for one-cycle pulses,
//                with a synchronous flush that empties the whole line.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_pulse_delay #(
    parameter int DLY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DLY-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (flush) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= din;
            for (int i = 1; i < DLY; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign dout = r_sr[DLY-1];

endmodule
`default_nettype wire

// File: rtl/fp_stage_enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fp_stage_enable_sequencer
//  Description : Periodic stage-0 enable pulse generator with a delayed pulse
//                per downstream pipeline stage and a busy indication.
//                Optional pulse counter output enabled by FP_SEQ_PULSE_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_stage_enable_sequencer
    import fp_ctrl_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int STAGE_DLY     = DEF_STAGE_DLY,
    parameter int DRAIN_ON_STOP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena_fft_core,
    input  logic [CNT_W-1:0]      period_cfg,
    output logic [NUM_STAGES-1:0] ena_stage,
    output logic                  busy
`ifdef FP_SEQ_PULSE_CNT_EN
    ,
    output logic [15:0]           pulse_cnt
`endif
);

    // Cycles a pulse spends in the chain after leaving stage 0.
    localparam int c_DRAIN_LEN = (NUM_STAGES - 1) * STAGE_DLY;
    localparam int c_TMR_W     = $clog2((MAX_STAGES - 1) * MAX_STAGE_DLY + 1);

    logic [CNT_W-1:0]      r_period_q;
    logic [CNT_W-1:0]      r_count;
    logic                  r_stage0;
    logic [c_TMR_W-1:0]    r_drain_tmr;
    logic                  w_issue;
    logic                  w_flush;
    logic [NUM_STAGES-1:0] w_stage;

    assign w_issue = ena_fft_core & (r_count == r_period_q);
    assign w_flush = (DRAIN_ON_STOP == 0) ? ~ena_fft_core : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_q <= '0;
            r_count    <= '0;
            r_stage0   <= 1'b0;
        end else if (ena_fft_core) begin
            if (w_issue) begin
                r_count  <= '0;
                r_stage0 <= 1'b1;
            end else begin
                r_count  <= r_count + 1'b1;
                r_stage0 <= 1'b0;
            end
        end else begin
            r_period_q <= period_cfg;
            r_count    <= '0;
            r_stage0   <= 1'b0;
        end
    end

    assign w_stage[0] = r_stage0;

    generate
        for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
            fp_pulse_delay #(
                .DLY (STAGE_DLY)
            ) u_dly (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (w_flush),
                .din   (w_stage[k-1]),
                .dout  (w_stage[k])
            );
        end
    endgenerate

    assign ena_stage = w_stage;

    // Non-zero exactly while the newest issued pulse sits inside the chain
    // between stage 0 and the last stage, so the delay lines need not expose
    // their internal bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_tmr <= '0;
        end else if (w_flush) begin
            r_drain_tmr <= '0;
        end else if (w_issue) begin
            r_drain_tmr <= c_TMR_W'(c_DRAIN_LEN);
        end else if (r_drain_tmr != '0) begin
            r_drain_tmr <= r_drain_tmr - 1'b1;
        end
    end

    assign busy = rst_n & (ena_fft_core | (|w_stage) | (r_drain_tmr != '0));

`ifdef FP_SEQ_PULSE_CNT_EN
    logic        r_ena_d;
    logic [15:0] r_pulse_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena_d     <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_ena_d <= ena_fft_core;
            if (ena_fft_core && !r_ena_d) begin
                r_pulse_cnt <= 16'(w_issue);
            end else if (w_issue) begin
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
        end
    end

    assign pulse_cnt = r_pulse_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_stage_enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_stage_enable_sequencer
//  Description : Self-checking bench for three sequencer configurations driven
//                in lock-step against a pulse-history reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_stage_enable_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] period;

    logic [1:0] st_a;
    logic [2:0] st_b;
    logic [1:0] st_c;
    logic       busy_a, busy_b, busy_c;
`ifdef FP_SEQ_PULSE_CNT_EN
    logic [15:0] pc_a, pc_b, pc_c;
`endif

    always #5 clk = ~clk;

    fp_stage_enable_sequencer #(.CNT_W(4), .NUM_STAGES(2), .STAGE_DLY(10), .DRAIN_ON_STOP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena_fft_core(ena), .period_cfg(period),
        .ena_stage(st_a), .busy(busy_a)
`ifdef FP_SEQ_PULSE_CNT_EN
        , .pulse_cnt(pc_a)
`endif
    );

    fp_stage_enable_sequencer #(.CNT_W(4), .NUM_STAGES(3), .STAGE_DLY(2), .DRAIN_ON_STOP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena_fft_core(ena), .period_cfg(period),
        .ena_stage(st_b), .busy(busy_b)
`ifdef FP_SEQ_PULSE_CNT_EN
        , .pulse_cnt(pc_b)
`endif
    );

    fp_stage_enable_sequencer #(.CNT_W(4), .NUM_STAGES(2), .STAGE_DLY(10), .DRAIN_ON_STOP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .ena_fft_core(ena), .period_cfg(period),
        .ena_stage(st_c), .busy(busy_c)
`ifdef FP_SEQ_PULSE_CNT_EN
        , .pulse_cnt(pc_c)
`endif
    );

    // Reference model: hist[t] = a stage-0 pulse was issued at edge t; a pulse
    // reaches stage k at edge t+k*D unless a reset (or, without drain, a
    // disabled edge) happened after it was issued.
    bit          hist [0:131071];
    int          cyc;
    int          last_rst;
    int          last_flush;
    int          n_run;
    int          p_q;
    bit          prev_ena;
    logic [15:0] m_pcnt;
    int          checks;
    int          errors;

    function automatic bit alive(int t0, bit drain);
        if (t0 < 0) return 1'b0;
        return hist[t0] && (t0 > last_rst) && (drain || (t0 > last_flush));
    endfunction

    function automatic logic [7:0] exp_st(int ns, int d, bit drain);
        logic [7:0] r = '0;
        for (int k = 0; k < ns; k++) r[k] = alive(cyc - k * d, drain);
        return r;
    endfunction

    function automatic bit exp_busy(int ns, int d, bit drain);
        bit b;
        if (!rst_n) return 1'b0;
        b = ena;
        for (int t0 = cyc - (ns - 1) * d; t0 <= cyc; t0++) b |= alive(t0, drain);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] e;
        e = exp_st(2, 10, 1'b1);
        chk("stage_a", 16'(st_a), 16'(e[1:0]));
        e = exp_st(3, 2, 1'b1);
        chk("stage_b", 16'(st_b), 16'(e[2:0]));
        e = exp_st(2, 10, 1'b0);
        chk("stage_c", 16'(st_c), 16'(e[1:0]));
        chk("busy_a", 16'(busy_a), 16'(exp_busy(2, 10, 1'b1)));
        chk("busy_b", 16'(busy_b), 16'(exp_busy(3, 2, 1'b1)));
        chk("busy_c", 16'(busy_c), 16'(exp_busy(2, 10, 1'b0)));
`ifdef FP_SEQ_PULSE_CNT_EN
        chk("pcnt_a", pc_a, m_pcnt);
        chk("pcnt_b", pc_b, m_pcnt);
        chk("pcnt_c", pc_c, m_pcnt);
`endif
    endtask

    task automatic model_edge();
        cyc++;
        hist[cyc] = 1'b0;
        if (!rst_n) begin
            last_rst = cyc;
            n_run    = 0;
            p_q      = 0;
            m_pcnt   = '0;
        end else if (ena) begin
            if (!prev_ena) m_pcnt = '0;
            n_run++;
            hist[cyc] = ((n_run % (p_q + 1)) == 0);
            if (hist[cyc]) m_pcnt = m_pcnt + 16'd1;
        end else begin
            p_q        = int'(period);
            n_run      = 0;
            last_flush = cyc;
        end
        prev_ena = rst_n && ena;
    endtask

    task automatic step(input bit e, input logic [3:0] p);
        ena    = e;
        period = p;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n    = 1'b0;
        last_rst = cyc;
        n_run    = 0;
        p_q      = 0;
        prev_ena = 1'b0;
        m_pcnt   = '0;
        #1;
        check_all();
        step(ena, period);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        cyc = 0; last_rst = 0; last_flush = 0; n_run = 0; p_q = 0;
        prev_ena = 1'b0; m_pcnt = '0;
        rst_n = 1'b0; ena = 1'b0; period = 4'd0;
        #1;
        check_all();
        step(1'b0, 4'd0);
        rst_n = 1'b1;

        // Period 9: stage-0 pulses after enabled edges 10/20/30/40.
        step(1'b0, 4'd9);
        for (int i = 1; i <= 43; i++) begin
            step(1'b1, 4'd9);
            if (i == 10 || i == 20 || i == 30) chk("a_s0_pulse", 16'(st_a[0]), 16'd1);
            if (i == 20 || i == 30 || i == 40) chk("a_s1_pulse", 16'(st_a[1]), 16'd1);
        end
        // Enable drops 3 cycles after the pulse at edge 40.
        step(1'b0, 4'd9);
        chk("c_busy_flushed", 16'(busy_c), 16'd0);
        chk("a_busy_draining", 16'(busy_a), 16'd1);
        for (int i = 45; i <= 49; i++) step(1'b0, 4'd9);
        step(1'b0, 4'd9);
        chk("a_drained_s1", 16'(st_a[1]), 16'd1);
        chk("c_no_s1", 16'(st_c[1]), 16'd0);
        step(1'b0, 4'd9);
        chk("a_busy_fall", 16'(busy_a), 16'd0);

        // Period change while enabled is ignored until the next disable.
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, (i <= 5) ? 4'd9 : 4'd3);
            if (i == 20) chk("p_hold_s0", 16'(st_a[0]), 16'd1);
            if (i == 8)  chk("p_hold_gap", 16'(st_a[0]), 16'd0);
        end
        step(1'b0, 4'd3);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 4'd3);
            if (i == 4 || i == 8 || i == 12) chk("p3_s0", 16'(st_a[0]), 16'd1);
        end

        // Period 0 on the 3-stage / delay-2 instance.
        for (int i = 0; i < 25; i++) step(1'b0, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 4'd0);
            if (i == 1) chk("b_p0_c1", 16'(st_b), 16'h1);
            if (i == 3) chk("b_p0_c3", 16'(st_b), 16'h3);
            if (i == 5) chk("b_p0_c5", 16'(st_b), 16'h7);
        end

        // Reset in the middle of a period-9 run.
        step(1'b0, 4'd9);
        for (int i = 1; i <= 15; i++) step(1'b1, 4'd9);
        async_reset();
        chk("rst_a_zero", 16'(st_a), 16'd0);
        for (int i = 1; i <= 30; i++) step(1'b1, 4'd9);

        // Randomized run with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 6)));
            end
        end

`ifdef FP_SEQ_PULSE_CNT_EN
        async_reset();
        step(1'b0, 4'd0);
        for (int i = 1; i <= 65537; i++) step(1'b1, 4'd0);
        chk("pcnt_wrap", pc_a, 16'd1);
        async_reset();
        chk("pcnt_rst", pc_a, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
